// File: rtl/en_strobe_gen.sv
// ---------------------------------------------------------------------------
// en_strobe_gen
//   Programmable clock-enable generator. Its en output feeds the enable pins
//   of downstream DFFE registers so those registers update once every
//   (div+1) clocks. A run is either a fixed burst of en pulses or, with
//   burst = 0, continuous until aborted.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   clr        asynchronous active-high reset, forces IDLE and clears outputs
//   start      begin a run (only honoured in IDLE)
//   abort      end the current run (honoured in RUN; in IDLE it blocks start)
//   div        enable period minus one, captured when a start is accepted
//   burst      number of en pulses per run, 0 = continuous, captured on start
//   en         registered one-cycle enable strobe (held high when div = 0)
//   busy       high while a run is in progress (RUN or DONE)
//   done       one-cycle pulse after the last pulse of a finite burst
//   pulse_cnt  number of en pulses issued in the current / last run
// ---------------------------------------------------------------------------
module en_strobe_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [DIV_W-1:0] r_pre;
  logic [DIV_W-1:0] r_divR;
  logic [CNT_W-1:0] r_burstR;
  logic [CNT_W-1:0] r_pulseCnt;
  logic             r_en;
  logic             r_busy;
  logic             r_done;

  logic [DIV_W-1:0] w_preNext;
  logic [DIV_W-1:0] w_divNext;
  logic [CNT_W-1:0] w_burstNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_cntInc;
  logic             w_enNext;
  logic             w_busyNext;
  logic             w_doneNext;

  // Pulse count after the pulse about to be issued; it wraps naturally in
  // continuous mode and is compared against the latched burst length to
  // detect the final pulse of a finite run.
  assign w_cntInc = r_pulseCnt + 1'b1;

  // State and every output are registered here so that nothing downstream
  // sees a combinational path from the inputs. clr clears everything at once,
  // including the latched divisor and burst length.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_pre      <= '0;
      r_divR     <= '0;
      r_burstR   <= '0;
      r_pulseCnt <= '0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pre      <= w_preNext;
      r_divR     <= w_divNext;
      r_burstR   <= w_burstNext;
      r_pulseCnt <= w_cntNext;
      r_en       <= w_enNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
    end
  end

  // Next-state and next-output logic. en and done are strobes, so they
  // default low and are raised only in the cycle that calls for them; the
  // remaining registers default to holding their value.
  always_comb begin
    w_stateNext = r_state;
    w_preNext   = r_pre;
    w_divNext   = r_divR;
    w_burstNext = r_burstR;
    w_cntNext   = r_pulseCnt;
    w_enNext    = 1'b0;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busyNext = 1'b0;
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          w_divNext   = div;
          w_burstNext = burst;
          w_preNext   = div;
          w_cntNext   = '0;
          w_busyNext  = 1'b1;
          w_stateNext = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // pulse_cnt keeps the count reached so far
          w_busyNext  = 1'b0;
          w_stateNext = ST_IDLE;
        end else if (r_pre == '0) begin
          w_enNext  = 1'b1;
          w_preNext = r_divR;
          w_cntNext = w_cntInc;
          if ((r_burstR != '0) && (w_cntInc == r_burstR)) begin
            w_stateNext = ST_DONE;
          end
        end else begin
          w_preNext = r_pre - 1'b1;
        end
      end

      ST_DONE: begin
        // abort is deliberately ignored here so done always pulses
        w_doneNext  = 1'b1;
        w_busyNext  = 1'b0;
        w_stateNext = ST_IDLE;
      end

      default: begin
        w_busyNext  = 1'b0;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign en        = r_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulseCnt;

endmodule

// File: tb/tb_en_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_en_strobe_gen
//   Self-checking bench for en_strobe_gen (CNT_W = 4 so counter wrap is
//   reachable). Expected per-cycle outputs are derived from closed-form
//   timing of a run, pushed to a queue as stimulus is applied, and popped
//   and compared one clock later.
// ---------------------------------------------------------------------------
module tb_en_strobe_gen;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          clr;
  logic          start;
  logic          abort;
  logic [DW-1:0] div;
  logic [CW-1:0] burst;
  logic          en;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_cnt;

  typedef struct {
    logic          en;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total;
  int   bad;

  en_strobe_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .div       (div),
    .burst     (burst),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs t cycles after the edge that accepted a start
  // (t = 0 is that edge), for divisor d and burst length b.
  function automatic exp_t model(input int d, input int b, input int t);
    exp_t r;
    int   p;
    int   last;
    int   n;
    p      = d + 1;
    last   = b * p;
    r.en   = (t >= 1) && ((t % p) == 0) && ((b == 0) || (t <= last));
    r.busy = (b == 0) || (t <= last);
    r.done = (b != 0) && (t == last + 1);
    n      = t / p;
    if ((b != 0) && (n > b)) n = b;
    r.cnt  = CW'(n % (1 << CW));
    return r;
  endfunction

  function automatic exp_t idleExp(input int c);
    exp_t r;
    r.en   = 1'b0;
    r.busy = 1'b0;
    r.done = 1'b0;
    r.cnt  = CW'(c);
    return r;
  endfunction

  task automatic applyStimulus(input int d, input int b);
    div   = DW'(d);
    burst = CW'(b);
    start = 1'b1;
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    div   = '0;
    burst = '0;
    @(posedge clk); #1;
    total++;
    if ({en, busy, done, pulse_cnt} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("[TB] FAIL reset_hold got en=%b busy=%b done=%b cnt=%0d want all 0", en, busy, done, pulse_cnt);
    end
    clr = 1'b0;
    applyStimulus(2, 0);
    for (int t = 0; t < 7; t++) q.push_back(model(2, 0, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL reset_prerun t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
    // assert clr between edges; outputs must clear before the next edge
    #1 clr = 1'b1;
    #1;
    total++;
    if ({en, busy, done, pulse_cnt} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("[TB] FAIL reset_async got en=%b busy=%b done=%b cnt=%0d want all 0", en, busy, done, pulse_cnt);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int t = 0; t < 6; t++) q.push_back(idleExp(0));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL reset_after t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_finite_burst();
    applyStimulus(3, 4);
    for (int t = 0; t < 21; t++) q.push_back(model(3, 4, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL finite_burst t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_div_zero();
    applyStimulus(0, 5);
    for (int t = 0; t < 9; t++) q.push_back(model(0, 5, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL div_zero t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_continuous_abort();
    applyStimulus(1, 0);
    // 19 pulses by t=39 -> count 19 mod 16 = 3, wrap to 0 seen at t=32
    for (int t = 0; t < 40; t++) q.push_back(model(1, 0, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL continuous t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
    // abort lands on what would have been a pulse edge; the count holds at 3
    abort = 1'b1;
    for (int t = 0; t < 3; t++) q.push_back(idleExp(3));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL abort_run t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 3);
    for (int t = 0; t < 10; t++) q.push_back(model(1, 3, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      // keep re-requesting with different settings while busy (edges 1..6),
      // then drop start before the block returns to IDLE
      start = (t < 6);
      div   = DW'(7);
      burst = CW'(9);
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL restart_ignored t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_simultaneous();
    // start and abort together in IDLE: nothing starts, count from last run kept
    applyStimulus(0, 2);
    abort = 1'b1;
    for (int t = 0; t < 3; t++) q.push_back(idleExp(3));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL start_abort_idle t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
    // abort during the DONE cycle (edge 3 of a div=0, burst=2 run)
    applyStimulus(0, 2);
    for (int t = 0; t < 6; t++) q.push_back(model(0, 2, t));
    for (int t = 0; q.size() > 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (t == 2);
      e = q.pop_front();
      total++;
      if ({en, busy, done, pulse_cnt} !== {e.en, e.busy, e.done, e.cnt}) begin
        bad++;
        $display("[TB] FAIL abort_in_done t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, en, busy, done, pulse_cnt, e.en, e.busy, e.done, e.cnt);
      end
    end
    abort = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_finite_burst();
    test_div_zero();
    test_continuous_abort();
    test_back_to_back();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
